// File: rtl/chk_stream_scoreboard_pkg.sv
// Shared constants and helpers for the stream scoreboard and its FIFO.
// Flag bit positions index the sticky status vector inside the scoreboard.
package chk_stream_scoreboard_pkg;

    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_TIMEOUT   = 2;
    localparam int FLAG_FRAME     = 3;
    localparam int FLAG_NUM       = 4;

    localparam int FRAME_CNT_W    = 16;
    localparam int LENQ_AW        = 2;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int chk_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/chk_sync_fifo.sv
// Single-clock FIFO with synchronous flush, full/empty and occupancy outputs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module chk_sync_fifo
    import chk_stream_scoreboard_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [chk_log2(DEPTH):0]   o_fill
);
    localparam int AW = chk_log2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // A push while full is only accepted when a pop frees the head slot.
    assign w_wr_en = i_push & (~o_full | i_pop);
    assign w_rd_en = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_fill  = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = ({~r_wr_ptr[AW], r_wr_ptr[AW-1:0]} == r_rd_ptr);

endmodule

// File: rtl/chk_stream_scoreboard.sv
// Scoreboard comparing a DUT's output pixel stream against its buffered input,
// with sticky status flags, error counting and per-frame length checking.
module chk_stream_scoreboard
    import chk_stream_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_NUM   = 4,
    parameter int DATA_DEPTH    = 64,
    parameter int STOP_ON_ERROR = 0,
    parameter int MAX_LATENCY   = 1024,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                i_chk_en,
    input  logic [CHANNEL_NUM-1:0]              iv_chan_mask,
    input  logic                                i_fval_in,
    input  logic                                i_lval_in,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0]   iv_pix_data_in,
    input  logic                                i_fval_out,
    input  logic                                i_lval_out,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0]   iv_pix_data_out,
    output logic [ERR_CNT_WIDTH-1:0]            ov_err_cnt,
    output logic [CHANNEL_NUM-1:0]              ov_chan_err,
    output logic                                o_overflow,
    output logic                                o_underflow,
    output logic                                o_timeout,
    output logic                                o_frame_err,
    output logic [chk_log2(DATA_DEPTH):0]       ov_fill,
    output logic [FRAME_CNT_W-1:0]              ov_frame_cnt
);
    localparam int AW    = chk_log2(DATA_DEPTH);
    localparam int DW    = DATA_WIDTH * CHANNEL_NUM;
    localparam int AGE_W = chk_log2(MAX_LATENCY + 1);
    localparam logic [AGE_W-1:0]         AGE_MAX = AGE_W'(MAX_LATENCY);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    logic                    w_push, w_pop, w_flush, w_bypass;
    logic                    w_fifo_push, w_fifo_pop, w_cmp_fire;
    logic                    w_full, w_empty;
    logic [DW-1:0]           w_head, w_expected;
    logic [AW:0]             w_fill;
    logic [CHANNEL_NUM-1:0]  w_mismatch;
    logic [AGE_W-1:0]        w_age_next;
    logic                    w_in_rise, w_in_fall, w_out_rise, w_out_fall;
    logic                    w_lenq_empty, w_lenq_full, w_frame_err;
    logic [FRAME_CNT_W-1:0]  w_lenq_head;

    logic                    r_chk_en_d;
    logic                    r_cmp_valid;
    logic [CHANNEL_NUM-1:0]  r_mismatch;
    logic [DW-1:0]           r_got, r_exp;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [CHANNEL_NUM-1:0]  r_chan_err;
    logic [FLAG_NUM-1:0]     r_flags;
    logic [AGE_W-1:0]        r_age;
    logic                    r_fval_in_d, r_fval_out_d, r_in_track, r_out_track;
    logic [FRAME_CNT_W-1:0]  r_in_cnt, r_out_cnt, r_frame_cnt;
    logic [FRAME_CNT_W-1:0]  r_lenq [1 << LENQ_AW];
    logic [LENQ_AW:0]        r_lenq_wr, r_lenq_rd;

    assign w_push      = i_chk_en & i_fval_in & i_lval_in;
    assign w_pop       = i_chk_en & i_fval_out & i_lval_out;
    assign w_flush     = r_chk_en_d & ~i_chk_en;
    // An empty FIFO with a simultaneous push and pop compares straight against the input beat.
    assign w_bypass    = w_empty & w_push & w_pop;
    assign w_fifo_push = w_push & ~w_bypass;
    assign w_fifo_pop  = w_pop & ~w_empty;
    assign w_cmp_fire  = w_fifo_pop | w_bypass;
    assign w_expected  = w_bypass ? iv_pix_data_in : w_head;

    chk_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DATA_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_flush),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (iv_pix_data_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (w_fill)
    );

    always_comb begin
        w_mismatch = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            w_mismatch[k] = iv_chan_mask[k] &
                (iv_pix_data_out[k*DATA_WIDTH +: DATA_WIDTH] != w_expected[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        w_age_next = r_age;
        if (w_pop || (w_fill == '0)) begin
            w_age_next = '0;
        end else if (r_age != AGE_MAX) begin
            w_age_next = r_age + 1'b1;
        end
    end

    // The compare result is registered first; counters and channel flags follow one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chk_en_d  <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_mismatch  <= '0;
            r_got       <= '0;
            r_exp       <= '0;
            r_err_cnt   <= '0;
            r_chan_err  <= '0;
            r_flags     <= '0;
            r_age       <= '0;
        end else begin
            r_chk_en_d  <= i_chk_en;
            r_cmp_valid <= w_cmp_fire;
            r_mismatch  <= w_cmp_fire ? w_mismatch : '0;
            r_got       <= iv_pix_data_out;
            r_exp       <= w_expected;
            r_age       <= w_age_next;
            if (r_cmp_valid && (|r_mismatch)) begin
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                r_chan_err <= r_chan_err | r_mismatch;
            end
            if (w_push && w_full && !w_pop) begin
                r_flags[FLAG_OVERFLOW] <= 1'b1;
            end
            if (w_pop && w_empty && !w_push) begin
                r_flags[FLAG_UNDERFLOW] <= 1'b1;
            end
            if (w_age_next == AGE_MAX) begin
                r_flags[FLAG_TIMEOUT] <= 1'b1;
            end
            if (w_frame_err) begin
                r_flags[FLAG_FRAME] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (STOP_ON_ERROR != 0 && r_cmp_valid && (|r_mismatch)) begin
            $error("chk_stream_scoreboard: data error at %0t got %h expected %h", $time, r_got, r_exp);
            $stop;
        end
    end

    // Edge detectors start high so a frame already in flight at reset release is ignored.
    assign w_in_rise    = i_fval_in & ~r_fval_in_d;
    assign w_in_fall    = ~i_fval_in & r_fval_in_d & r_in_track;
    assign w_out_rise   = i_fval_out & ~r_fval_out_d;
    assign w_out_fall   = ~i_fval_out & r_fval_out_d & r_out_track;
    assign w_lenq_empty = (r_lenq_wr == r_lenq_rd);
    assign w_lenq_full  = ({~r_lenq_wr[LENQ_AW], r_lenq_wr[LENQ_AW-1:0]} == r_lenq_rd);
    assign w_lenq_head  = r_lenq[r_lenq_rd[LENQ_AW-1:0]];
    assign w_frame_err  = w_out_fall & (w_lenq_empty | (w_lenq_head != r_out_cnt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fval_in_d  <= 1'b1;
            r_fval_out_d <= 1'b1;
            r_in_track   <= 1'b0;
            r_out_track  <= 1'b0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_frame_cnt  <= '0;
            r_lenq_wr    <= '0;
            r_lenq_rd    <= '0;
            for (int i = 0; i < (1 << LENQ_AW); i++) begin
                r_lenq[i] <= '0;
            end
        end else begin
            r_fval_in_d  <= i_fval_in;
            r_fval_out_d <= i_fval_out;
            if (w_in_rise) begin
                r_in_track <= 1'b1;
                r_in_cnt   <= FRAME_CNT_W'(w_push);
            end else if (w_in_fall) begin
                r_in_track <= 1'b0;
            end else if (w_push && r_in_track) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end
            if (w_out_rise) begin
                r_out_track <= 1'b1;
                r_out_cnt   <= FRAME_CNT_W'(w_pop);
            end else if (w_out_fall) begin
                r_out_track <= 1'b0;
            end else if (w_pop && r_out_track) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            if (w_out_fall) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_flush) begin
                r_lenq_wr <= '0;
                r_lenq_rd <= '0;
            end else begin
                if (w_in_fall && !w_lenq_full) begin
                    r_lenq[r_lenq_wr[LENQ_AW-1:0]] <= r_in_cnt;
                    r_lenq_wr <= r_lenq_wr + 1'b1;
                end
                if (w_out_fall && !w_lenq_empty) begin
                    r_lenq_rd <= r_lenq_rd + 1'b1;
                end
            end
        end
    end

    assign ov_err_cnt   = r_err_cnt;
    assign ov_chan_err  = r_chan_err;
    assign o_overflow   = r_flags[FLAG_OVERFLOW];
    assign o_underflow  = r_flags[FLAG_UNDERFLOW];
    assign o_timeout    = r_flags[FLAG_TIMEOUT];
    assign o_frame_err  = r_flags[FLAG_FRAME];
    assign ov_fill      = w_fill;
    assign ov_frame_cnt = r_frame_cnt;

endmodule
